// File: rtl/dispense_sequencer_pkg.sv
// Shared definitions for the spiral dispense sequencer: FSM state encoding,
// keypad key codes and the keypad matrix decoder.
package dispense_sequencer_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ARMED = 3'd1;
   localparam state_t ST_RUN   = 3'd2;
   localparam state_t ST_GAP   = 3'd3;
   localparam state_t ST_FAULT = 3'd4;

   typedef logic [3:0] key_t;

   localparam key_t KEY_0    = 4'h0;
   localparam key_t KEY_1    = 4'h1;
   localparam key_t KEY_2    = 4'h2;
   localparam key_t KEY_3    = 4'h3;
   localparam key_t KEY_4    = 4'h4;
   localparam key_t KEY_5    = 4'h5;
   localparam key_t KEY_6    = 4'h6;
   localparam key_t KEY_7    = 4'h7;
   localparam key_t KEY_8    = 4'h8;
   localparam key_t KEY_9    = 4'h9;
   localparam key_t KEY_DEL  = 4'hA;
   localparam key_t KEY_OK   = 4'hB;
   localparam key_t KEY_NONE = 4'hF;

   function automatic logic key_is_digit(input key_t k);
      return (k >= KEY_1) && (k <= KEY_9);
   endfunction

   // Only an exactly one-hot row and column select a key; anything else is no key.
   function automatic key_t decode_key(input logic [2:0] col, input logic [3:0] row);
      key_t k;
      k = KEY_NONE;
      case ({row, col})
         7'b1000_100: k = KEY_1;
         7'b1000_010: k = KEY_2;
         7'b1000_001: k = KEY_3;
         7'b0100_100: k = KEY_4;
         7'b0100_010: k = KEY_5;
         7'b0100_001: k = KEY_6;
         7'b0010_100: k = KEY_7;
         7'b0010_010: k = KEY_8;
         7'b0010_001: k = KEY_9;
         7'b0001_100: k = KEY_DEL;
         7'b0001_010: k = KEY_0;
         7'b0001_001: k = KEY_OK;
         default:     k = KEY_NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/dispense_sequencer_key_debouncer.sv
// Keypad debouncer: registers the decoded key and emits a single accept strobe
// once the same key has been seen for DEB_CYCLES consecutive cycles.
module key_debouncer
   import dispense_sequencer_pkg::*;
#(
   parameter int DEB_CYCLES = 16
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] coluna,
   input  logic [3:0] linha,
   output logic [3:0] key_code,
   output logic       key_valid
);

   localparam int               CNT_W   = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   key_t             raw;
   key_t             code_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic             vld_p0;

   assign raw = decode_key(coluna, linha);

   // Stage p0: registered key code, run-length count and accept strobe.
   // The count saturates so a held key never strobes twice; a change of code
   // reloads it to one, counting the first cycle of the new code.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         code_p0 <= KEY_NONE;
         cnt_p0  <= '0;
         vld_p0  <= 1'b0;
      end else begin
         code_p0 <= raw;
         vld_p0  <= 1'b0;
         if (raw != code_p0) begin
            cnt_p0 <= CNT_ONE;
            vld_p0 <= (CNT_ONE == CNT_MAX) && (raw != KEY_NONE);
         end else if (cnt_p0 != CNT_MAX) begin
            cnt_p0 <= cnt_p0 + CNT_ONE;
            vld_p0 <= (cnt_p0 == CNT_MAX - CNT_ONE) && (raw != KEY_NONE);
         end
      end
   end

   assign key_code  = code_p0;
   assign key_valid = vld_p0;

endmodule

// File: rtl/dispense_sequencer.sv
// Spiral motor transaction controller: keypad selection of 1-9 turns, relay
// drive, turn counting from the sensor pair, abort and no-turn timeout fault.
module dispense_sequencer
   import dispense_sequencer_pkg::*;
#(
   parameter int DEB_CYCLES     = 16,
   parameter int SENS_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_W           = 20
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] coluna,
   input  logic [3:0] linha,
   input  logic       sensor1,
   input  logic       sensor2,
   output logic       rele,
   output logic       busy,
   output logic [3:0] turns_left,
   output logic       done,
   output logic       fault
);

   localparam int              SC_W    = $clog2(SENS_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(SENS_CYCLES);
   localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   logic [3:0]      key_code;
   logic            key_valid;
   logic            both;
   logic [SC_W-1:0] scnt_p0;
   logic            turn_p0;
   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic            key_del;
   logic            key_ok;
   logic            key_dig;
   logic            turn_hit;
   logic            timed_out;

   key_debouncer #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_keys (
      .clock     (clock),
      .reset     (reset),
      .coluna    (coluna),
      .linha     (linha),
      .key_code  (key_code),
      .key_valid (key_valid)
   );

   assign both = sensor1 & sensor2;

   // Stage p0: sensor qualifier, one strobe per continuous high period.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scnt_p0 <= '0;
         turn_p0 <= 1'b0;
      end else begin
         turn_p0 <= 1'b0;
         if (!both) begin
            scnt_p0 <= '0;
         end else if (scnt_p0 != SC_MAX) begin
            scnt_p0 <= scnt_p0 + SC_ONE;
            turn_p0 <= (scnt_p0 == SC_MAX - SC_ONE);
         end
      end
   end

   assign key_del   = key_valid && (key_code == KEY_DEL);
   assign key_ok    = key_valid && (key_code == KEY_OK);
   assign key_dig   = key_valid && key_is_digit(key_code);
   assign turn_hit  = turn_p0 && (state == ST_RUN);
   assign timed_out = (to_cnt == TO_LAST);

   // Transaction FSM; relay and status outputs are registered alongside state.
   // Within RUN/GAP the branch order encodes abort > turn > timeout.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         turns_left <= 4'd0;
         to_cnt     <= '0;
         rele       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (key_dig) begin
                  state      <= ST_ARMED;
                  turns_left <= key_code;
               end
            end
            ST_ARMED: begin
               if (key_dig) begin
                  turns_left <= key_code;
               end else if (key_del) begin
                  state      <= ST_IDLE;
                  turns_left <= 4'd0;
               end else if (key_ok) begin
                  state  <= ST_RUN;
                  to_cnt <= '0;
                  rele   <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            ST_RUN, ST_GAP: begin
               if (key_del) begin
                  state      <= ST_IDLE;
                  turns_left <= 4'd0;
                  to_cnt     <= '0;
                  rele       <= 1'b0;
                  busy       <= 1'b0;
               end else if (turn_hit) begin
                  to_cnt <= '0;
                  if (turns_left <= 4'd1) begin
                     state      <= ST_IDLE;
                     turns_left <= 4'd0;
                     done       <= 1'b1;
                     rele       <= 1'b0;
                     busy       <= 1'b0;
                  end else begin
                     state      <= ST_GAP;
                     turns_left <= turns_left - 4'd1;
                  end
               end else if (timed_out) begin
                  state  <= ST_FAULT;
                  to_cnt <= '0;
                  rele   <= 1'b0;
                  busy   <= 1'b0;
                  fault  <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_ONE;
                  if ((state == ST_GAP) && !both) begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_FAULT: begin
               if (key_del) begin
                  state      <= ST_IDLE;
                  turns_left <= 4'd0;
                  fault      <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               turns_left <= 4'd0;
               to_cnt     <= '0;
               rele       <= 1'b0;
               busy       <= 1'b0;
               fault      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: directed scenarios plus randomized keypad and
// sensor traffic, every cycle compared against a behavioural reference model.
module tb_dispense_sequencer;

   localparam int DEB  = 16;
   localparam int SENS = 16;
   localparam int TMO  = 100;

   localparam int P_IDLE  = 0;
   localparam int P_ARMED = 1;
   localparam int P_RUN   = 2;
   localparam int P_GAP   = 3;
   localparam int P_FAULT = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] coluna;
   logic [3:0] linha;
   logic       sensor1;
   logic       sensor2;
   logic       rele;
   logic       busy;
   logic [3:0] turns_left;
   logic       done;
   logic       fault;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_phase, m_turns, m_done, m_cyc, m_deadline;
   int k_prev, k_run, k_evt, s_run;
   bit s_evt;
   int done_cnt;
   bit rele_seen;

   dispense_sequencer #(
      .DEB_CYCLES     (DEB),
      .SENS_CYCLES    (SENS),
      .TIMEOUT_CYCLES (TMO),
      .TO_W           (7)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .coluna     (coluna),
      .linha      (linha),
      .sensor1    (sensor1),
      .sensor2    (sensor2),
      .rele       (rele),
      .busy       (busy),
      .turns_left (turns_left),
      .done       (done),
      .fault      (fault)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Key number from a keypad pattern: 1-9 digits, 0, 10=DEL, 11=OK, 15=none.
   function automatic int key_of(input logic [2:0] c, input logic [3:0] r);
      int ci, ri;
      if ($countones(c) != 1 || $countones(r) != 1) return 15;
      ci = 0;
      ri = 0;
      for (int i = 0; i < 3; i++) if (c[2-i]) ci = i;
      for (int i = 0; i < 4; i++) if (r[3-i]) ri = i;
      if (ri < 3) return ri * 3 + ci + 1;
      if (ci == 0) return 10;
      if (ci == 1) return 0;
      return 11;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_turns = 0; m_done = 0; m_cyc = 0; m_deadline = 0;
      k_prev = 15; k_run = 0; k_evt = -1; s_run = 0; s_evt = 0;
   endtask

   // One rising edge: controller reacts to keys/turns accepted at the previous edge.
   task automatic model_step();
      int key;
      m_cyc++;
      m_done = 0;
      case (m_phase)
         P_IDLE: if (k_evt >= 1 && k_evt <= 9) begin
            m_phase = P_ARMED; m_turns = k_evt;
         end
         P_ARMED: begin
            if (k_evt >= 1 && k_evt <= 9) m_turns = k_evt;
            else if (k_evt == 10) begin m_phase = P_IDLE; m_turns = 0; end
            else if (k_evt == 11) begin m_phase = P_RUN; m_deadline = m_cyc + TMO; end
         end
         P_RUN, P_GAP: begin
            if (k_evt == 10) begin
               m_phase = P_IDLE; m_turns = 0;
            end else if (s_evt && m_phase == P_RUN) begin
               m_turns = m_turns - 1;
               m_deadline = m_cyc + TMO;
               if (m_turns == 0) begin m_phase = P_IDLE; m_done = 1; end
               else m_phase = P_GAP;
            end else if (m_cyc == m_deadline) begin
               m_phase = P_FAULT;
            end else if (m_phase == P_GAP && !(sensor1 && sensor2)) begin
               m_phase = P_RUN;
            end
         end
         P_FAULT: if (k_evt == 10) begin m_phase = P_IDLE; m_turns = 0; end
         default: ;
      endcase
      key = key_of(coluna, linha);
      k_run = (key == k_prev) ? k_run + 1 : 1;
      k_prev = key;
      k_evt = (k_run == DEB && key != 15) ? key : -1;
      s_run = (sensor1 && sensor2) ? s_run + 1 : 0;
      s_evt = (s_run == SENS);
   endtask

   task automatic tick();
      logic [7:0] exp;
      bit act;
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
      @(negedge clock);
      act = (m_phase == P_RUN || m_phase == P_GAP);
      exp = {act, act, m_done[0], (m_phase == P_FAULT), m_turns[3:0]};
      chk("outs", {rele, busy, done, fault, turns_left}, exp);
      if (done === 1'b1) done_cnt++;
      if (rele === 1'b1) rele_seen = 1'b1;
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   task automatic set_key(input int key);
      case (key)
         0:  begin coluna = 3'b010; linha = 4'b0001; end
         10: begin coluna = 3'b100; linha = 4'b0001; end
         11: begin coluna = 3'b001; linha = 4'b0001; end
         15: begin coluna = 3'b000; linha = 4'b0000; end
         default: begin
            coluna = 3'b100 >> ((key - 1) % 3);
            linha  = 4'b1000 >> ((key - 1) / 3);
         end
      endcase
   endtask

   task automatic press(input int key, input int n, input int rel);
      set_key(key);
      hold(n);
      set_key(15);
      hold(rel);
   endtask

   task automatic sens(input bit v);
      sensor1 = v;
      sensor2 = v;
   endtask

   task automatic pulse(input int hi, input int lo);
      sens(1'b1);
      hold(hi);
      sens(1'b0);
      hold(lo);
   endtask

   task automatic select_confirm(input int d);
      press(d, DEB, 2);
      press(11, DEB, 1);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      set_key(15);
      sens(1'b0);
      model_reset();
      hold(3);
      chk("reset", {rele, busy, done, fault, turns_left}, 8'h00);
      reset = 1'b0;
      hold(2);

      // 1: select 3, confirm, three turns
      press(3, DEB, 2);
      set_key(11);
      hold(DEB);
      set_key(15);
      chk("t1_pre_rele", rele, 1'b0);
      hold(1);
      chk("t1_rele", rele, 1'b1);
      chk("t1_turns", turns_left, 4'd3);
      done_cnt = 0;
      pulse(SENS, 8);
      chk("t1_turn1", turns_left, 4'd2);
      pulse(SENS, 8);
      chk("t1_turn2", turns_left, 4'd1);
      pulse(SENS, 8);
      chk("t1_turn3", turns_left, 4'd0);
      chk("t1_rele_off", rele, 1'b0);
      chk("t1_done", done_cnt, 1);

      // 2: short press is not accepted
      rele_seen = 1'b0;
      press(5, 10, 2);
      press(11, DEB, 4);
      chk("t2_turns", turns_left, 4'd0);
      chk("t2_rele", rele_seen, 1'b0);

      // 3: one long sensor pulse counts once
      select_confirm(2);
      done_cnt = 0;
      sens(1'b1);
      hold(60);
      chk("t3_turns", turns_left, 4'd1);
      chk("t3_rele", rele, 1'b1);
      sens(1'b0);
      hold(4);
      pulse(SENS, 4);
      chk("t3_done", done_cnt, 1);
      chk("t3_rele_off", rele, 1'b0);

      // 4: no-turn timeout
      press(1, DEB, 2);
      set_key(11);
      n = 0;
      while (rele !== 1'b1 && n < 40) begin tick(); n++; end
      set_key(15);
      chk("t4_rele_rise", rele, 1'b1);
      n = 0;
      while (fault !== 1'b1 && n < 200) begin tick(); n++; end
      chk("t4_timeout", n, TMO);
      chk("t4_rele", rele, 1'b0);
      press(11, DEB, 2);
      chk("t4_ok_ignored", fault, 1'b1);
      press(10, DEB, 2);
      chk("t4_cleared", fault, 1'b0);

      // 5: abort after one turn
      select_confirm(4);
      pulse(SENS, 8);
      chk("t5_turns", turns_left, 4'd3);
      done_cnt = 0;
      set_key(10);
      hold(DEB);
      set_key(15);
      chk("t5_still_on", rele, 1'b1);
      hold(1);
      chk("t5_rele", rele, 1'b0);
      chk("t5_turns0", turns_left, 4'd0);
      hold(2);
      chk("t5_no_done", done_cnt, 0);

      // 6: reset mid-GAP, then held key needs a fresh debounce
      select_confirm(2);
      sens(1'b1);
      hold(SENS + 4);
      chk("t6_in_gap", turns_left, 4'd1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("t6_async", {rele, busy, done, fault, turns_left}, 8'h00);
      sens(1'b0);
      set_key(7);
      hold(2);
      reset = 1'b0;
      hold(DEB);
      chk("t6_not_yet", turns_left, 4'd0);
      hold(1);
      chk("t6_armed", turns_left, 4'd7);
      press(10, DEB, 2);

      // randomized traffic
      for (int it = 0; it < 300; it++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 45) begin
            set_key($urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) sens(1'b1);
            hold($urandom_range(6, 24));
            set_key(15);
            sens(1'b0);
            hold($urandom_range(1, 6));
         end else if (r < 85) begin
            sensor1 = 1'b1;
            sensor2 = ($urandom_range(0, 5) != 0);
            hold($urandom_range(1, 30));
            sens(1'b0);
            hold($urandom_range(1, 12));
         end else if (r < 95) begin
            coluna = 3'($urandom);
            linha  = 4'($urandom);
            hold($urandom_range(10, 20));
            set_key(15);
            hold(2);
         end else begin
            reset = 1'b1;
            model_reset();
            #1;
            chk("rnd_reset", {rele, busy, done, fault, turns_left}, 8'h00);
            hold(1);
            reset = 1'b0;
            hold(1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
